// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
// calc_sequencer: command-driven operand/operator sequencer in front of the ALU.
// Chains results through the accumulator, which drives ALU operand A.
module calc_sequencer #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_type,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_err,
  output logic             cmd_illegal
);

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_OPER = 2'b01;
  localparam logic [1:0] C_EQ   = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  localparam logic [SEL_W-1:0] SEL_ADD = '0;
  localparam logic [SEL_W-1:0] SEL_SUB = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_DIV = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_NOT = '1;

  typedef enum logic [2:0] {
    S_A, S_OP, S_B, S_EXEC, S_RES
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic             res_err_q, res_err_d;
  logic             illegal_q, illegal_d;
  logic             fire;

  assign cmd_ready   = (state_q == S_A) || (state_q == S_OP) || (state_q == S_B);
  assign fire        = cmd_valid & cmd_ready;
  assign res_valid   = (state_q == S_RES);
  assign alu_a       = acc_q;
  assign alu_b       = b_q;
  assign alu_sel     = sel_q;
  assign res_data    = res_data_q;
  assign res_carry   = res_carry_q;
  assign res_err     = res_err_q;
  assign cmd_illegal = illegal_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    sel_d       = sel_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    illegal_d   = 1'b0;
    if (fire && cmd_type == C_CLR) begin
      acc_d   = '0;
      b_d     = '0;
      sel_d   = '0;
      state_d = S_A;
    end else begin
      unique case (state_q)
        S_A: begin
          if (fire) begin
            if (cmd_type == C_LOAD) begin
              acc_d   = cmd_data;
              state_d = S_OP;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        S_OP: begin
          if (fire) begin
            unique case (cmd_type)
              C_LOAD: acc_d = cmd_data;
              C_OPER: begin
                sel_d   = cmd_data[SEL_W-1:0];
                state_d = (cmd_data[SEL_W-1:0] == SEL_NOT) ? S_EXEC : S_B;
              end
              C_EQ: begin
                res_data_d  = acc_q;
                res_carry_d = 1'b0;
                res_err_d   = 1'b0;
                state_d     = S_RES;
              end
              default: ;
            endcase
          end
        end
        S_B: begin
          if (fire) begin
            if (cmd_type == C_LOAD) begin
              b_d     = cmd_data;
              state_d = S_EXEC;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        S_EXEC: begin
          // Divide by zero is trapped here; the ALU's own output is ignored.
          if (sel_q == SEL_DIV && b_q == '0) begin
            acc_d       = '0;
            res_data_d  = '0;
            res_err_d   = 1'b1;
            res_carry_d = 1'b0;
          end else begin
            acc_d       = alu_out;
            res_data_d  = alu_out;
            res_err_d   = 1'b0;
            res_carry_d = alu_carry & (sel_q == SEL_ADD || sel_q == SEL_SUB);
          end
          state_d = S_RES;
        end
        S_RES: begin
          if (res_ready) state_d = res_err_q ? S_A : S_OP;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      acc_q       <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
// tb_calc_sequencer: directed plan plus random command stream against
// an arithmetic reference model; a behavioural ALU closes the loop.
module tb_calc_sequencer;

  localparam int W  = 16;
  localparam int SW = 3;
  localparam logic [1:0] LD = 2'd0;
  localparam logic [1:0] OP = 2'd1;
  localparam logic [1:0] EQ = 2'd2;
  localparam logic [1:0] CL = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = 2'd0;
  logic [W-1:0]  cmd_data = '0;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [SW-1:0] alu_sel;
  logic          alu_carry;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_data;
  logic          res_carry, res_err, cmd_illegal;

  always #5 clk = ~clk;

  calc_sequencer #(.WIDTH(W), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
    .res_err(res_err), .cmd_illegal(cmd_illegal)
  );

  // Behavioural ALU; carry is deliberately 1 for ops where it is meaningless.
  logic [W:0] alu_t;
  always_comb begin
    alu_t     = '0;
    alu_out   = '0;
    alu_carry = 1'b1;
    case (alu_sel)
      3'd0: begin
        alu_t     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = alu_t[W-1:0];
        alu_carry = alu_t[W];
      end
      3'd1: begin
        alu_t     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out   = alu_t[W-1:0];
        alu_carry = alu_t[W];
      end
      3'd2: alu_out = alu_a * alu_b;
      3'd3: alu_out = (alu_b == '0) ? '1 : alu_a / alu_b;
      3'd4: alu_out = alu_a & alu_b;
      3'd5: alu_out = alu_a | alu_b;
      3'd6: alu_out = alu_a ^ alu_b;
      default: alu_out = ~alu_a;
    endcase
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = want operand, 1 = want operator, 2 = want B.
  int          m_phase = 0;
  logic [15:0] m_acc = '0;
  logic [15:0] m_b = '0;
  logic [2:0]  m_sel = '0;
  logic [15:0] m_exp_data = '0;
  logic        m_exp_err = 1'b0;
  bit          auto_acc = 1'b1;
  logic [15:0] last_data = '0;
  logic        last_carry = 1'b0;
  logic        last_err = 1'b0;
  logic        last_ill = 1'b0;

  task automatic model_op(input logic [2:0] s, input logic [15:0] a,
                          input logic [15:0] b, output logic [15:0] v,
                          output logic c, output logic e);
    int x;
    v = '0; c = 1'b0; e = 1'b0;
    case (s)
      3'd0: begin
        x = int'(a) + int'(b);
        v = 16'(x);
        c = (x > 65535);
      end
      3'd1: begin
        v = 16'(int'(a) - int'(b));
        c = (a < b);
      end
      3'd2: v = 16'(longint'(a) * longint'(b));
      3'd3: if (b == 0) e = 1'b1; else v = a / b;
      3'd4: v = a & b;
      3'd5: v = a | b;
      3'd6: v = a ^ b;
      default: v = ~a;
    endcase
  endtask

  task automatic accept_result();
    int stall;
    stall = $urandom_range(0, 3);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_data", 32'(res_data), 32'(m_exp_data));
      check("stall_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    m_phase = m_exp_err ? 0 : 1;
    @(negedge clk);
    check("valid_fall", 32'(res_valid), 32'd0);
    check("acc_chain", 32'(alu_a), 32'(m_acc));
  endtask

  task automatic send(input logic [1:0] t, input logic [15:0] d);
    int n;
    int cnt;
    bit pend;
    bit exec;
    logic ill;
    logic [15:0] ev;
    logic ec, ee;
    n = 0; pend = 0; exec = 0; ill = 1'b0;
    ev = '0; ec = 1'b0; ee = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = t; cmd_data = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (t == CL) begin
      m_acc = '0; m_b = '0; m_sel = '0; m_phase = 0;
    end else begin
      case (m_phase)
        0: if (t == LD) begin m_acc = d; m_phase = 1; end else ill = 1'b1;
        1: begin
          if (t == LD) m_acc = d;
          else if (t == OP) begin
            m_sel = d[2:0];
            if (m_sel == 3'd7) begin pend = 1; exec = 1; end
            else m_phase = 2;
          end else begin
            pend = 1; ev = m_acc;
          end
        end
        default: if (t == LD) begin
          m_b = d; pend = 1; exec = 1;
        end else ill = 1'b1;
      endcase
    end
    if (exec) begin
      model_op(m_sel, m_acc, m_b, ev, ec, ee);
      m_acc = ee ? 16'h0 : ev;
    end
    m_exp_data = ev;
    m_exp_err = ee;
    @(negedge clk);
    last_ill = cmd_illegal;
    check("illegal", 32'(cmd_illegal), 32'(ill));
    if (!pend) begin
      check("alu_a", 32'(alu_a), 32'(m_acc));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_sel", 32'(alu_sel), 32'(m_sel));
      return;
    end
    cnt = 0;
    while (!res_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 32'(cnt), exec ? 32'd1 : 32'd0);
    check("res_data", 32'(res_data), 32'(ev));
    check("res_carry", 32'(res_carry), 32'(ec));
    check("res_err", 32'(res_err), 32'(ee));
    last_data = res_data; last_carry = res_carry; last_err = res_err;
    if (auto_acc) accept_result();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [1:0] t;
    logic [15:0] d;
    #12;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b} ^ 32'(alu_sel)), 32'd0);
    check("rst_ill", 32'(cmd_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    send(LD, 16'h0005); send(OP, 16'h0000); send(LD, 16'h0003);
    check("p1_data", 32'(last_data), 32'h0008);
    check("p1_carry", 32'(last_carry), 32'd0);

    send(LD, 16'hFFFF); send(OP, 16'h0000); send(LD, 16'h0002);
    check("p2_data", 32'(last_data), 32'h0001);
    check("p2_carry", 32'(last_carry), 32'd1);
    send(OP, 16'h0002); send(LD, 16'h0003);
    check("p2_mul", 32'(last_data), 32'h0003);
    check("p2_mask", 32'(last_carry), 32'd0);

    send(LD, 16'h0003); send(OP, 16'h0001); send(LD, 16'h0005);
    check("p3_sub", 32'(last_data), 32'hFFFE);
    check("p3_borrow", 32'(last_carry), 32'd1);
    send(LD, 16'h00FF); send(OP, 16'h0007);
    check("p3_not", 32'(last_data), 32'hFF00);

    send(LD, 16'h0007); send(OP, 16'h0003); send(LD, 16'h0000);
    check("p4_data", 32'(last_data), 32'h0000);
    check("p4_err", 32'(last_err), 32'd1);
    send(OP, 16'h0000);
    check("p4_ill", 32'(last_ill), 32'd1);

    auto_acc = 1'b0;
    send(LD, 16'h1234); send(OP, 16'h0000); send(LD, 16'h1111);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'h2345);
      check("hold_ready", 32'(cmd_ready), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_alu_a", 32'(alu_a), 32'd0);
    check("arst_data", 32'(res_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0; m_acc = '0; m_b = '0; m_sel = '0;
    auto_acc = 1'b1;

    send(LD, 16'h0010); send(EQ, 16'h0000);
    check("p6_eq", 32'(last_data), 32'h0010);
    send(OP, 16'h0000); send(CL, 16'h0000);
    check("p6_clr_a", 32'(alu_a), 32'd0);
    check("p6_clr_b", 32'(alu_b), 32'd0);
    check("p6_clr_sel", 32'(alu_sel), 32'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) t = LD;
      else if (r < 72) t = OP;
      else if (r < 88) t = EQ;
      else t = CL;
      r = $urandom_range(0, 5);
      if (r == 0) d = 16'h0000;
      else if (r == 1) d = 16'($urandom_range(1, 20));
      else d = 16'($urandom);
      send(t, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
